// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder.
//   DSRAM_ADDR_W : default word-address width
//   LANE_W       : bits per byte lane
//   NUM_LANES    : byte lanes per 32-bit word
//   dsram_req_t  : commit-request bus {en, wen}, same shape as the EX-to-MEM data_ram fields
//   dsram_state_e: responder FSM states
//   lane_parity(): even-parity bit per byte lane
package data_sram_responder_pkg;

    localparam int unsigned DSRAM_ADDR_W = 10;
    localparam int unsigned LANE_W       = 8;
    localparam int unsigned NUM_LANES    = 4;

    typedef struct packed {
        logic                 en;
        logic [NUM_LANES-1:0] wen;
    } dsram_req_t;

    localparam int unsigned REQ_W = $bits(dsram_req_t);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } dsram_state_e;

    // Bit i is set when lane i holds an odd number of ones, so lane plus bit is even.
    function automatic logic [NUM_LANES-1:0] lane_parity(input logic [31:0] data);
        logic [NUM_LANES-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            p[i] = ^data[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/data_sram_responder_dsram_array.sv
// Byte-lane write-enabled 32-bit storage with one synchronous port.
// Optional per-lane even parity storage when DSRAM_PARITY_EN is defined.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (resets rdata only, not contents)
//   en_i          : access commits at this edge
//   wen_i         : byte write enables; 0 with en_i is a read
//   idx_i         : word index
//   wdata_i       : store data
//   rdata_o       : registered read data
//   par_bad_o     : parity mismatch on the word being read this cycle (0 without parity)
module data_sram_responder_dsram_array
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned AddrW = DSRAM_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [NUM_LANES-1:0] wen_i,
    input  logic [AddrW-1:0]     idx_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 par_bad_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;
    logic        rd_en;

    assign rd_en = en_i && (wen_i == '0);

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wen_i[i]) begin
                    mem_q[idx_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef DSRAM_PARITY_EN
    logic [NUM_LANES-1:0] par_q [Depth];
    logic [NUM_LANES-1:0] wpar;

    assign wpar = lane_parity(wdata_i);

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wen_i[i]) begin
                    par_q[idx_i][i] <= wpar[i];
                end
            end
        end
    end

    assign par_bad_o = rd_en && (par_q[idx_i] != lane_parity(mem_q[idx_i]));
`else
    assign par_bad_o = 1'b0;
`endif

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: slave end of the data_sram_* interface.
// Byte-enabled writes, word reads, read data registered one cycle after commit.
// WAIT_CYCLES > 0 inserts wait states and raises stallreq while the access is pending.
// Optional feature macro: DSRAM_PARITY_EN (per-lane parity, sticky parity_err).
// Ports:
//   clk, resetn      : clock, async active-low reset
//   data_sram_en     : access request
//   data_sram_wen    : byte write enables (0 = read)
//   data_sram_addr   : byte address, bits [ADDR_W+1:2] select the word
//   data_sram_wdata  : store data
//   data_sram_rdata  : registered read data
//   stallreq         : hold request stable while high
//   parity_err       : sticky parity error (0 without DSRAM_PARITY_EN)
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DSRAM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 data_sram_en,
    input  logic [NUM_LANES-1:0] data_sram_wen,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 stallreq,
    output logic                 parity_err
);

    localparam bit          WaitEn  = (WAIT_CYCLES != 0);
    localparam int unsigned CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(WaitEn ? WAIT_CYCLES - 1 : 0);

    logic [ADDR_W-1:0] req_idx;
    assign req_idx = data_sram_addr[ADDR_W+1:2];

    // Byte offset and bits above the array wrap are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    dsram_state_e         state_q;
    logic [CntW-1:0]      cnt_q;
    logic [NUM_LANES-1:0] cap_wen_q;
    logic [ADDR_W-1:0]    cap_idx_q;
    logic [31:0]          cap_wdata_q;

    // Request is captured on entry to StWait; inputs are ignored until commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cap_wen_q   <= '0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (WaitEn && data_sram_en) begin
                        state_q     <= StWait;
                        cnt_q       <= CntInit;
                        cap_wen_q   <= data_sram_wen;
                        cap_idx_q   <= req_idx;
                        cap_wdata_q <= data_sram_wdata;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    dsram_req_t           commit_req;
    logic [ADDR_W-1:0]    commit_idx;
    logic [31:0]          commit_wdata;

    always_comb begin
        commit_req.en  = data_sram_en;
        commit_req.wen = data_sram_wen;
        commit_idx     = req_idx;
        commit_wdata   = data_sram_wdata;
        if (WaitEn) begin
            commit_req.en  = (state_q == StWait) && (cnt_q == '0);
            commit_req.wen = cap_wen_q;
            commit_idx     = cap_idx_q;
            commit_wdata   = cap_wdata_q;
        end
        // Reset aborts anything in flight, including a zero-wait access.
        commit_req.en = commit_req.en && resetn;
    end

    always_comb begin
        stallreq = resetn && WaitEn &&
                   (((state_q == StIdle) && data_sram_en) ||
                    ((state_q == StWait) && (cnt_q != '0)));
    end

    logic par_bad;

    data_sram_responder_dsram_array #(
        .AddrW (ADDR_W)
    ) u_array (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .en_i      (commit_req.en),
        .wen_i     (commit_req.wen),
        .idx_i     (commit_idx),
        .wdata_i   (commit_wdata),
        .rdata_o   (data_sram_rdata),
        .par_bad_o (par_bad)
    );

`ifdef DSRAM_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q | par_bad;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_par_bad;
    assign unused_par_bad = par_bad;
    assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) driven one at a time,
// compared against a word-array reference model kept here.
module tb_data_sram_responder;

    localparam int NumDut = 3;

    function automatic int unsigned wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    logic        clk;
    logic        resetn;
    logic        en    [NumDut];
    logic [3:0]  wen   [NumDut];
    logic [31:0] addr  [NumDut];
    logic [31:0] wdata [NumDut];
    logic [31:0] rdata [NumDut];
    logic        stall [NumDut];
    logic        perr  [NumDut];

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        data_sram_responder #(
            .ADDR_W      (10),
            .WAIT_CYCLES (wait_of(g))
        ) u_dut (
            .clk             (clk),
            .resetn          (resetn),
            .data_sram_en    (en[g]),
            .data_sram_wen   (wen[g]),
            .data_sram_addr  (addr[g]),
            .data_sram_wdata (wdata[g]),
            .data_sram_rdata (rdata[g]),
            .stallreq        (stall[g]),
            .parity_err      (perr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] mem_m    [NumDut][1024];
    logic [3:0]  badl_m   [NumDut][1024];
    logic [31:0] rdata_m  [NumDut];
    logic        perr_m   [NumDut];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the commit.
    task automatic access(input int k, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int unsigned wc;
        logic [9:0]  ix;
        wc = wait_of(k);
        ix = a[11:2];
        en[k]    = 1'b1;
        wen[k]   = w;
        addr[k]  = a;
        wdata[k] = d;
        #1;
        check({tag, ":stall_t0"}, 32'(stall[k]), 32'(wc != 0));
        for (int j = 1; j <= int'(wc); j++) begin
            @(posedge clk);
            @(negedge clk);
            // Requester misbehaves during the wait; must not affect the committed access.
            en[k]    = 1'($urandom_range(0, 1));
            wen[k]   = 4'($urandom);
            addr[k]  = $urandom;
            wdata[k] = $urandom;
            #1;
            check({tag, ":stall_w"}, 32'(stall[k]), 32'(j < int'(wc)));
        end
        @(posedge clk);
        @(negedge clk);
        en[k] = 1'b0;
        if (w == 4'h0) begin
            rdata_m[k] = mem_m[k][ix];
            if (badl_m[k][ix] != 4'h0) perr_m[k] = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) begin
                    mem_m[k][ix][8*i +: 8] = d[8*i +: 8];
                    badl_m[k][ix][i]       = 1'b0;
                end
            end
        end
        #1;
        check({tag, ":rdata"}, rdata[k], rdata_m[k]);
        check({tag, ":perr"}, 32'(perr[k]), 32'(perr_m[k]));
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NumDut; k++) begin
            check({tag, ":rdata"}, rdata[k], 32'h0);
            check({tag, ":stall"}, 32'(stall[k]), 32'h0);
            check({tag, ":perr"}, 32'(perr[k]), 32'h0);
        end
    endtask

    task automatic clear_model_regs();
        for (int k = 0; k < NumDut; k++) begin
            rdata_m[k] = '0;
            perr_m[k]  = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a_val;
        resetn = 1'b0;
        for (int k = 0; k < NumDut; k++) begin
            en[k] = 1'b0; wen[k] = '0; addr[k] = '0; wdata[k] = '0;
            for (int i = 0; i < 1024; i++) badl_m[k][i] = 4'h0;
        end
        clear_model_regs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state("por");
        resetn = 1'b1;

        // Known contents for words 0..15 of every instance
        for (int k = 0; k < NumDut; k++) begin
            for (int i = 0; i < 16; i++) begin
                access(k, 4'hF, 32'(i) << 2, $urandom, "init");
            end
        end

        // Zero-wait full-word write then read
        access(0, 4'hF, 32'h10, 32'hDEADBEEF, "w0_wr");
        access(0, 4'h0, 32'h10, 32'h0, "w0_rd");
        check("deadbeef", rdata[0], 32'hDEADBEEF);

        // Mixed byte lanes
        access(0, 4'hF, 32'h20, 32'h11223344, "lane_wr");
        access(0, 4'b0101, 32'h20, 32'hAABBCCDD, "lane_wr2");
        access(0, 4'h0, 32'h20, 32'h0, "lane_rd");
        check("lanes", rdata[0], 32'h11BB33DD);

        // Address wrap and ignored byte offset, zero-wait and W=3
        for (int k = 0; k < NumDut; k += 2) begin
            access(k, 4'hF, 32'h1000, 32'hCAFE0000 + 32'(k), "wrap_wr");
            access(k, 4'h0, 32'h0, 32'h0, "wrap_rd0");
            check("wrap_word0", rdata[k], 32'hCAFE0000 + 32'(k));
            access(k, 4'h0, 32'h3, 32'h0, "wrap_rd3");
        end

        // W=3 back-to-back: next request issued in the cycle rdata becomes valid
        access(2, 4'h0, 32'h20, 32'h0, "w3_rd_a");
        access(2, 4'h0, 32'h24, 32'h0, "w3_rd_b");

        // Randomised mix on all instances
        for (int k = 0; k < NumDut; k++) begin
            for (int n = 0; n < 60; n++) begin
                logic [31:0] up;
                logic [3:0]  w;
                up = $urandom;
                w  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                access(k, w, {up[31:12], 6'h0, 4'($urandom_range(0, 15)), up[1:0]},
                       $urandom, "rand");
            end
        end

        // Reset mid-wait on W=2: store aborted, rdata/stall drop at once
        access(1, 4'hF, 32'h14, 32'h5A5A1234, "rst_pre_wr");
        access(1, 4'h0, 32'h14, 32'h0, "rst_pre_rd");
        en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h14; wdata[1] = 32'h0BAD0BAD;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        clear_model_regs();
        check_reset_state("midwait_rst");
        @(posedge clk);
        @(negedge clk);
        en[1] = 1'b0;
        resetn = 1'b1;
        access(1, 4'h0, 32'h14, 32'h0, "rst_post_rd");
        check("rst_aborted", rdata[1], 32'h5A5A1234);

`ifdef DSRAM_PARITY_EN
        access(0, 4'hF, 32'h1C, 32'h0F0F0F0F, "par_wr");
        a_val = g_dut[0].u_dut.u_array.mem_q[7];
        a_val[3] = ~a_val[3];
        g_dut[0].u_dut.u_array.mem_q[7] = a_val;
        mem_m[0][7]  = a_val;
        badl_m[0][7] = 4'b0001;
        access(0, 4'h0, 32'h1C, 32'h0, "par_rd");
        check("par_set", 32'(perr[0]), 32'h1);
        access(0, 4'h0, 32'h0, 32'h0, "par_clean0");
        access(0, 4'h0, 32'h4, 32'h0, "par_clean1");
        check("par_sticky", 32'(perr[0]), 32'h1);
        resetn = 1'b0;
        #1;
        clear_model_regs();
        check("par_rst", 32'(perr[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
`else
        a_val = 32'h0;
        access(0, 4'h0, 32'h1C, a_val, "nopar_rd");
        check("nopar_perr", 32'(perr[0]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
